// File: rtl/wordle_pkg.sv
// Shared Wordle constants, FSM encoding and the letter range check for the guess evaluator.
// Colors: grey=0, yellow=1, green=2. Letters: blank=0, A=1 .. Z=26.
package wordle_pkg;

  localparam int NUM_COLS = 5;
  localparam int LETTER_W = 5;
  localparam int COLOR_W  = 2;
  localparam int CELL_W   = COLOR_W + LETTER_W;
  localparam int ROW_W    = NUM_COLS * LETTER_W;
  localparam int RES_W    = NUM_COLS * CELL_W;

  localparam logic [2:0] MAX_GUESSES = 3'd6;
  localparam logic [2:0] LAST_COL    = 3'd4;

  localparam logic [COLOR_W-1:0] COLOR_GREY   = 2'd0;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW = 2'd1;
  localparam logic [COLOR_W-1:0] COLOR_GREEN  = 2'd2;

  localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd0;
  localparam logic [LETTER_W-1:0] LETTER_A     = 5'd1;
  localparam logic [LETTER_W-1:0] LETTER_Z     = 5'd26;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic row_invalid(input logic [ROW_W-1:0] row);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (row[i*LETTER_W +: LETTER_W] < LETTER_A || row[i*LETTER_W +: LETTER_W] > LETTER_Z)
        bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/guess_evaluator_match.sv
// Combinational search for the lowest target column holding a letter that no earlier
// green/yellow has claimed yet.
module lowest_unused_match
  import wordle_pkg::*;
(
  input  logic [4:0]  letter,
  input  logic [24:0] target,
  input  logic [4:0]  used,
  output logic        found,
  output logic [2:0]  idx
);

  // Scan high to low so the lowest matching column is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    for (int j = NUM_COLS - 1; j >= 0; j--) begin
      if (!used[j] && target[j*LETTER_W +: LETTER_W] == letter) begin
        found = 1'b1;
        idx   = 3'(j);
      end
    end
  end

endmodule

// File: rtl/guess_evaluator.sv
// Scores one Wordle row: 5 green cycles, 5 yellow cycles, 1 done cycle; done 11 cycles after accept.
// Submits while busy or after game over are dropped. INVALID_CHECK_EN adds a letter range check with reject.
module guess_evaluator
  import wordle_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        submit,
  input  logic [24:0] guess,
  input  logic [24:0] target,
  input  logic        new_game,
  output logic        busy,
  output logic        done,
  output logic [34:0] result,
  output logic [2:0]  guess_count,
  output logic        win,
  output logic        game_over,
  output logic        reject
);

  state_t                               state_q;
  logic [2:0]                           col_q;
  logic [ROW_W-1:0]                     g_q;
  logic [ROW_W-1:0]                     t_q;
  logic [NUM_COLS-1:0]                  used_q;
  logic [NUM_COLS-1:0][COLOR_W-1:0]     color_q;

  logic [LETTER_W-1:0] cur_g;
  logic [LETTER_W-1:0] cur_t;
  logic                m_found;
  logic [2:0]          m_idx;
  logic                all_green;
  logic [2:0]          next_count;
  logic [RES_W-1:0]    res_next;
  logic                accept;

  assign accept     = submit && state_q == ST_IDLE && !game_over && !new_game;
  assign next_count = (guess_count == MAX_GUESSES) ? guess_count : guess_count + 3'd1;

  always_comb begin
    cur_g     = '0;
    cur_t     = '0;
    all_green = 1'b1;
    res_next  = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_q == 3'(i)) begin
        cur_g = g_q[i*LETTER_W +: LETTER_W];
        cur_t = t_q[i*LETTER_W +: LETTER_W];
      end
      if (color_q[i] != COLOR_GREEN) all_green = 1'b0;
      res_next[i*CELL_W +: CELL_W] = {color_q[i], g_q[i*LETTER_W +: LETTER_W]};
    end
  end

  lowest_unused_match u_match (
    .letter (cur_g),
    .target (t_q),
    .used   (used_q),
    .found  (m_found),
    .idx    (m_idx)
  );

`ifdef INVALID_CHECK_EN
  logic reject_q;
  assign reject = reject_q;
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      g_q         <= '0;
      t_q         <= '0;
      used_q      <= '0;
      color_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      guess_count <= '0;
      win         <= 1'b0;
      game_over   <= 1'b0;
`ifdef INVALID_CHECK_EN
      reject_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef INVALID_CHECK_EN
      reject_q <= 1'b0;
`endif
      // new_game outranks everything, including an evaluation in flight.
      if (new_game) begin
        guess_count <= '0;
        win         <= 1'b0;
        game_over   <= 1'b0;
        busy        <= 1'b0;
        state_q     <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              g_q     <= guess;
              t_q     <= target;
              col_q   <= '0;
              used_q  <= '0;
              color_q <= '0;
`ifdef INVALID_CHECK_EN
              if (row_invalid(guess)) begin
                reject_q <= 1'b1;
              end else begin
                busy    <= 1'b1;
                state_q <= ST_GREEN;
              end
`else
              busy    <= 1'b1;
              state_q <= ST_GREEN;
`endif
            end
          end
          ST_GREEN: begin
            if (cur_g == cur_t) begin
              color_q[col_q] <= COLOR_GREEN;
              used_q[col_q]  <= 1'b1;
            end
            if (col_q == LAST_COL) begin
              col_q   <= '0;
              state_q <= ST_YELLOW;
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
          ST_YELLOW: begin
            if (color_q[col_q] != COLOR_GREEN && m_found) begin
              color_q[col_q] <= COLOR_YELLOW;
              used_q[m_idx]  <= 1'b1;
            end
            if (col_q == LAST_COL) begin
              col_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
          ST_DONE: begin
            result      <= res_next;
            done        <= 1'b1;
            busy        <= 1'b0;
            guess_count <= next_count;
            win         <= all_green;
            game_over   <= all_green || next_count == MAX_GUESSES;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed bench for guess_evaluator: scoring, multiplicity, latency, game-over, new_game and reset abort.
module tb_guess_evaluator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        submit;
  logic [24:0] guess;
  logic [24:0] target;
  logic        new_game;
  logic        busy;
  logic        done;
  logic [34:0] result;
  logic [2:0]  guess_count;
  logic        win;
  logic        game_over;
  logic        reject;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [24:0] APPLE = {5'd5, 5'd12, 5'd16, 5'd16, 5'd1};
  localparam logic [24:0] PAPER = {5'd18, 5'd5, 5'd16, 5'd1, 5'd16};
  localparam logic [24:0] PUPPY = {5'd25, 5'd16, 5'd16, 5'd21, 5'd16};
  localparam logic [24:0] APBLE = {5'd5, 5'd12, 5'd0, 5'd16, 5'd1};
  // colors listed {c4,c3,c2,c1,c0}
  localparam logic [9:0] C_PAPER = {2'd0, 2'd1, 2'd2, 2'd1, 2'd1};
  localparam logic [9:0] C_PUPPY = {2'd0, 2'd0, 2'd2, 2'd0, 2'd1};
  localparam logic [9:0] C_APPLE = {2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  localparam logic [9:0] C_APBLE = {2'd2, 2'd2, 2'd0, 2'd2, 2'd2};

  guess_evaluator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .submit      (submit),
    .guess       (guess),
    .target      (target),
    .new_game    (new_game),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .guess_count (guess_count),
    .win         (win),
    .game_over   (game_over),
    .reject      (reject)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] exp_res(input logic [24:0] g, input logic [9:0] c);
    logic [34:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[i*7 +: 7] = {c[i*2 +: 2], g[i*5 +: 5]};
    return r;
  endfunction

  // Accept edge happens inside; returns just after it, inputs scrambled to prove latching.
  task automatic pulse_submit(input logic [24:0] g, input logic [24:0] t);
    guess  = g;
    target = t;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    guess  = 25'h1FFFFFF;
    target = 25'h0AAAAAA;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done === 1'b1) n++;
    end
  endtask

  initial begin
    int lat;
    int nd;
    int first;
    int cyc;
    logic [2:0] exp_count;

    rst_n = 1'b0; submit = 1'b0; new_game = 1'b0; guess = '0; target = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_count", 64'(guess_count), 64'd0);
    check("rst_win_go_rej", 64'({win, game_over, reject}), 64'd0);
    rst_n = 1'b1;
    tick();

    // PAPER vs APPLE
    pulse_submit(PAPER, APPLE);
    check("paper_busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("paper_latency", 64'(lat), 64'd11);
    check("paper_result", 64'(result), 64'(exp_res(PAPER, C_PAPER)));
    check("paper_count", 64'(guess_count), 64'd1);
    check("paper_win_go_busy", 64'({win, game_over, busy}), 64'd0);
    tick();
    check("paper_done_pulse", 64'(done), 64'd0);

    // PUPPY with a stray submit at +3 while busy
    pulse_submit(PUPPY, APPLE);
    cyc = 0;
    tick(); cyc++;
    tick(); cyc++;
    guess = APPLE; target = APPLE; submit = 1'b1;
    tick(); cyc++;
    submit = 1'b0;
    nd = 0; first = -1;
    while (cyc < 26) begin
      tick(); cyc++;
      if (done === 1'b1) begin
        nd++;
        if (first < 0) first = cyc;
      end
    end
    check("puppy_one_done", 64'(nd), 64'd1);
    check("puppy_latency", 64'(first), 64'd11);
    check("puppy_result", 64'(result), 64'(exp_res(PUPPY, C_PUPPY)));
    check("puppy_count", 64'(guess_count), 64'd2);
    exp_count = 3'd2;

`ifdef INVALID_CHECK_EN
    pulse_submit(APBLE, APPLE);
    check("inv_reject", 64'({reject, busy}), 64'b10);
    tick();
    check("inv_reject_pulse", 64'(reject), 64'd0);
    count_dones(15, nd);
    check("inv_no_done", 64'(nd), 64'd0);
    check("inv_count", 64'(guess_count), 64'(exp_count));
`else
    pulse_submit(APBLE, APPLE);
    wait_done(lat);
    exp_count = 3'd3;
    check("blank_result", 64'(result), 64'(exp_res(APBLE, C_APBLE)));
    check("blank_count", 64'(guess_count), 64'(exp_count));
`endif

    // Fill up to six non-winning guesses
    while (exp_count < 3'd6) begin
      tick();
      pulse_submit(PAPER, APPLE);
      wait_done(lat);
      exp_count = exp_count + 3'd1;
      check("fill_count", 64'(guess_count), 64'(exp_count));
    end
    check("full_go_win", 64'({game_over, win}), 64'b10);
    tick();
    pulse_submit(APPLE, APPLE);
    check("full_ignored_busy", 64'(busy), 64'd0);
    count_dones(15, nd);
    check("full_no_done", 64'(nd), 64'd0);
    check("full_count_sat", 64'(guess_count), 64'd6);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("newgame_clear", 64'({guess_count, game_over, win}), 64'd0);
    check("newgame_result_hold", 64'(result), 64'(exp_res(PAPER, C_PAPER)));

    // Winning row, then further submits dropped
    pulse_submit(APPLE, APPLE);
    wait_done(lat);
    check("win_latency", 64'(lat), 64'd11);
    check("win_result", 64'(result), 64'(exp_res(APPLE, C_APPLE)));
    check("win_flags", 64'({win, game_over, guess_count}), 64'({1'b1, 1'b1, 3'd1}));
    tick();
    pulse_submit(PAPER, APPLE);
    check("after_win_busy", 64'(busy), 64'd0);
    count_dones(15, nd);
    check("after_win_no_done", 64'(nd), 64'd0);

    // new_game and submit together: new_game wins, nothing starts
    guess = PAPER; target = APPLE; submit = 1'b1; new_game = 1'b1;
    tick();
    submit = 1'b0; new_game = 1'b0;
    check("ng_submit_busy", 64'(busy), 64'd0);
    check("ng_submit_clear", 64'({win, game_over, guess_count}), 64'd0);

    // new_game mid-evaluation aborts without done
    pulse_submit(PAPER, APPLE);
    tick(); tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("ng_abort_busy", 64'(busy), 64'd0);
    count_dones(15, nd);
    check("ng_abort_no_done", 64'({nd[3:0], guess_count}), 64'd0);

    // Reset at +5 aborts
    pulse_submit(PAPER, APPLE);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_outputs", 64'({busy, done, reject, win, game_over, guess_count}), 64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    count_dones(15, nd);
    check("rst_mid_no_done", 64'({nd[3:0], guess_count}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
